// File: rtl/irq_sched.sv
// irq_sched: edge-captured, masked, fixed-priority interrupt scheduler
// Ports: clk_25mhz/rst, irq_in, mask_*, glob_en, int_ack/done, ovr_clr -> int_req/vec/id, pending, overrun, busy
module irq_sched #(
  parameter int N_SRC = 4,
  parameter int VEC_W = 10,
  parameter logic [VEC_W-1:0] VEC0 = 10'h020,
  parameter logic [VEC_W-1:0] VEC1 = 10'h020,
  parameter logic [VEC_W-1:0] VEC2 = 10'h009,
  parameter logic [VEC_W-1:0] VEC3 = 10'h009
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             glob_en,
  input  logic             int_ack,
  input  logic             int_done,
  input  logic             ovr_clr,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  output logic [1:0]       int_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERV
  } state_t;

  state_t state, state_n;

  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] pending_n;
  logic [N_SRC-1:0] overrun_n;
  logic [1:0]       win;
  logic [VEC_W-1:0] win_vec;
  logic             ack_ok;
  logic             load;

  assign rise   = irq_in & ~prev;
  assign ack_ok = (state == REQ) & int_ack;
  assign clr    = ack_ok ? (N_SRC'(1) << int_id) : '0;
  assign elig   = pending & mask;

  // a rise in the ack cycle re-arms the bit, so it is not an overrun
  assign pending_n = (pending & ~clr) | rise;
  assign overrun_n = (ovr_clr ? '0 : overrun)
                   | (rise & pending & ~clr);

  assign int_req = (state == REQ);
  assign busy    = (state != IDLE);

  always_comb begin
    win = 2'd0;
    priority case (1'b1)
      elig[0]: win = 2'd0;
      elig[1]: win = 2'd1;
      elig[2]: win = 2'd2;
      elig[3]: win = 2'd3;
      default: win = 2'd0;
    endcase
  end

  always_comb begin
    win_vec = VEC0;
    unique case (win)
      2'd0: win_vec = VEC0;
      2'd1: win_vec = VEC1;
      2'd2: win_vec = VEC2;
      2'd3: win_vec = VEC3;
      default: win_vec = VEC0;
    endcase
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (glob_en && (elig != '0)) begin
          load    = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (int_ack) state_n = SERV;
      end
      SERV: begin
        if (int_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prev    <= '0;
      mask    <= '0;
      pending <= '0;
      overrun <= '0;
      int_id  <= 2'd0;
      int_vec <= '0;
    end else begin
      state   <= state_n;
      prev    <= irq_in;
      pending <= pending_n;
      overrun <= overrun_n;
      if (mask_we) mask <= mask_wdata;
      if (load) begin
        int_id  <= win;
        int_vec <= win_vec;
      end
    end
  end

endmodule
